// File: rtl/xlr8_dm_arb.sv
// rtl/xlr8_dm_arb.sv - data-memory port arbiter between the AVR core and one XB requester
module xlr8_dm_arb #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_dm_ce,
    input  logic        core_dm_we,
    input  logic [15:0] core_dm_adr,
    input  logic [7:0]  core_dm_dout,
    input  logic        xb_req,
    input  logic        xb_we,
    input  logic [15:0] xb_adr,
    input  logic [7:0]  xb_wdata,
    output logic        xb_gnt,
    output logic        xb_rvalid,
    output logic [7:0]  xb_rdata,
    output logic        core_hold,
    output logic        dm_ce,
    output logic        dm_we,
    output logic [15:0] dm_adr,
    output logic [7:0]  dm_dout,
    input  logic [7:0]  dm_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rvalid_q, rvalid_d;
    logic             starve_hit;

    // The core always wins unless it has been frozen for the XB.
    assign xb_gnt = xb_req & ~rst & ((state_q == S_HOLD) | ~core_dm_ce);

    assign starve_hit = (STARVE_LIMIT != 0) && (32'(wait_cnt_q) == STARVE_LIMIT - 1);

    always_comb begin
        dm_ce   = core_dm_ce;
        dm_we   = core_dm_we;
        dm_adr  = core_dm_adr;
        dm_dout = core_dm_dout;
        if (xb_gnt) begin
            dm_ce   = 1'b1;
            dm_we   = xb_we;
            dm_adr  = xb_adr;
            dm_dout = xb_wdata;
        end else if (state_q == S_HOLD && !rst) begin
            // Requester dropped its request while the core is frozen: no access at all.
            dm_ce = 1'b0;
            dm_we = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rvalid_d   = xb_gnt & ~xb_we;
        if (xb_gnt || !xb_req) begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
            state_d    = starve_hit ? S_HOLD : S_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign core_hold = (state_q == S_HOLD);
    assign xb_rvalid = rvalid_q;
    assign xb_rdata  = dm_din;

endmodule
